qdr_user_arbiter: RTL and testbench

QDR_USER_ARBITER -- requirements
Module: qdr_user_arbiter

---
 rtl/qdr_arb_pkg.sv | 21 ++
 rtl/qdr_tag_fifo.sv | 50 +++++
 rtl/qdr_user_arbiter.sv | 153 +++++++++++++++
 tb/tb_qdr_user_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdr_arb_pkg.sv
// Shared types for the two-requester QDR user arbiter: FSM states,
// requester IDs and the tag FIFO pointer width.
package qdr_arb_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_0 = 1'b0;
    localparam req_id_t REQ_1 = 1'b1;

    // One extra MSB beyond the index distinguishes full from empty.
    function automatic int tag_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/qdr_tag_fifo.sv
// Read-tag FIFO: remembers which requester owns each outstanding read so
// returns can be routed in issue order.
module qdr_tag_fifo
    import qdr_arb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic    clk0,
    input  logic    reset,
    input  logic    push,
    input  req_id_t push_id,
    input  logic    pop,
    output req_id_t pop_id,
    output logic    full,
    output logic    empty
);

    localparam int PW = tag_ptr_width(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    req_id_t       mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is fine.
    assign do_push = push && (!full || do_pop);
    assign pop_id  = mem[rd_ptr[IW-1:0]];

    always_ff @(posedge clk0) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk0) begin
        if (do_push) mem[wr_ptr[IW-1:0]] <= push_id;
    end

endmodule

// File: rtl/qdr_user_arbiter.sv
// Two-port round-robin front end for a QDR controller: grants one command per
// cycle, registers it to the controller and routes read returns by tag.
module qdr_user_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 36,
    parameter int BE_WIDTH   = 4,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                  clk0,
    input  logic                  reset,
    input  logic                  phy_rdy,
    input  logic                  cal_fail,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [BE_WIDTH-1:0]   be0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  rdvld0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [BE_WIDTH-1:0]   be1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  rdvld1,

    output logic [ADDR_WIDTH-1:0] usr_addr,
    output logic [DATA_WIDTH-1:0] usr_wr_data,
    output logic [BE_WIDTH-1:0]   usr_wr_be,
    output logic                  usr_wr_strb,
    output logic                  usr_rd_strb,
    input  logic [DATA_WIDTH-1:0] usr_rd_data,
    input  logic                  usr_rd_dvld,

    output logic                  ready,
    output logic                  fault,
    output logic                  err_spur
);

    arb_state_t state;
    arb_state_t state_nxt;
    req_id_t    last_grant;

    logic    tag_full;
    logic    tag_empty;
    logic    tag_pop;
    logic    tag_push;
    logic    tag_room;
    req_id_t tag_push_id;
    req_id_t tag_pop_id;
    logic    elig0;
    logic    elig1;

    // A return popping this cycle makes room for a read granted this cycle.
    assign tag_pop  = usr_rd_dvld && !tag_empty && !reset;
    assign tag_room = !tag_full || tag_pop;
    assign elig0    = req0 && (we0 || tag_room);
    assign elig1    = req1 && (we1 || tag_room);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        ack0      = 1'b0;
        ack1      = 1'b0;

        case (state)
            ST_INIT: begin
                if (cal_fail)     state_nxt = ST_FAULT;
                else if (phy_rdy) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cal_fail) state_nxt = ST_FAULT;
                if (!reset) begin
                    if (elig0 && elig1) begin
                        ack0 = (last_grant == REQ_1);
                        ack1 = (last_grant == REQ_0);
                    end else begin
                        ack0 = elig0;
                        ack1 = elig1;
                    end
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    assign tag_push    = (ack0 && !we0) || (ack1 && !we1);
    assign tag_push_id = ack1 ? REQ_1 : REQ_0;

    qdr_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk0    (clk0),
        .reset   (reset),
        .push    (tag_push),
        .push_id (tag_push_id),
        .pop     (tag_pop),
        .pop_id  (tag_pop_id),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk0) begin
        if (reset) begin
            state       <= ST_INIT;
            last_grant  <= REQ_1;
            usr_addr    <= '0;
            usr_wr_data <= '0;
            usr_wr_be   <= '0;
            usr_wr_strb <= 1'b0;
            usr_rd_strb <= 1'b0;
            err_spur    <= 1'b0;
        end else begin
            state       <= state_nxt;
            usr_wr_strb <= 1'b0;
            usr_rd_strb <= 1'b0;
            if (ack0) begin
                last_grant  <= REQ_0;
                usr_addr    <= addr0;
                usr_wr_data <= wdata0;
                usr_wr_be   <= be0;
                usr_wr_strb <= we0;
                usr_rd_strb <= !we0;
            end else if (ack1) begin
                last_grant  <= REQ_1;
                usr_addr    <= addr1;
                usr_wr_data <= wdata1;
                usr_wr_be   <= be1;
                usr_wr_strb <= we1;
                usr_rd_strb <= !we1;
            end
            if (usr_rd_dvld && tag_empty) err_spur <= 1'b1;
        end
    end

    assign rdata0 = usr_rd_data;
    assign rdata1 = usr_rd_data;
    assign rdvld0 = tag_pop && (tag_pop_id == REQ_0);
    assign rdvld1 = tag_pop && (tag_pop_id == REQ_1);

    assign ready  = (state == ST_RUN);
    assign fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_qdr_user_arbiter.sv
// Bench for qdr_user_arbiter: a queue-based reference model checked every cycle,
// a round-robin vector table, directed corner sequences and random traffic.
module tb_qdr_user_arbiter;

    localparam int AW = 22;
    localparam int DW = 36;
    localparam int BW = 4;
    localparam int TD = 16;

    logic          clk0;
    logic          reset, phy_rdy, cal_fail;
    logic          req0, we0, ack0, rdvld0;
    logic          req1, we1, ack1, rdvld1;
    logic [AW-1:0] addr0, addr1, usr_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, usr_wr_data, usr_rd_data;
    logic [BW-1:0] be0, be1, usr_wr_be;
    logic          usr_wr_strb, usr_rd_strb, usr_rd_dvld;
    logic          ready, fault, err_spur;

    qdr_user_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BE_WIDTH   (BW),
        .TAG_DEPTH  (TD)
    ) dut (
        .clk0        (clk0),
        .reset       (reset),
        .phy_rdy     (phy_rdy),
        .cal_fail    (cal_fail),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .be0         (be0),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .rdvld0      (rdvld0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .be1         (be1),
        .ack1        (ack1),
        .rdata1      (rdata1),
        .rdvld1      (rdvld1),
        .usr_addr    (usr_addr),
        .usr_wr_data (usr_wr_data),
        .usr_wr_be   (usr_wr_be),
        .usr_wr_strb (usr_wr_strb),
        .usr_rd_strb (usr_rd_strb),
        .usr_rd_data (usr_rd_data),
        .usr_rd_dvld (usr_rd_dvld),
        .ready       (ready),
        .fault       (fault),
        .err_spur    (err_spur)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 = waiting for PHY, 1 = running, 2 = failed calibration.
    int            m_state = 0;
    bit            m_q[$];
    bit            m_last  = 1'b1;
    bit            m_err   = 1'b0;
    logic          m_wstb  = 1'b0;
    logic          m_rstb  = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wd    = '0;
    logic [BW-1:0] m_be    = '0;

    bit            ob_ack0, ob_ack1, ob_rdvld0, ob_rdvld1;
    logic [DW-1:0] ob_rdata0, ob_rdata1;

    typedef struct {
        bit r0, r1, w0, w1, a0, a1;
    } vec_t;
    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs are already driven (posedge+1); compare at posedge+2, advance model, return at next posedge+1.
    task automatic tick();
        bit pop_ok, room, e0, e1, g0, g1, head;
        #1;
        head   = (m_q.size() > 0) ? m_q[0] : 1'b0;
        pop_ok = !reset && usr_rd_dvld && (m_q.size() > 0);
        room   = (m_q.size() < TD) || pop_ok;
        e0     = !reset && (m_state == 1) && req0 && (we0 || room);
        e1     = !reset && (m_state == 1) && req1 && (we1 || room);
        g0     = e0 && (!e1 || m_last);
        g1     = e1 && !g0;

        check("ack", {ack0, ack1}, {g0, g1});
        check("rdvld", {rdvld0, rdvld1}, {pop_ok && !head, pop_ok && head});
        if (pop_ok) check("rdata", head ? rdata1 : rdata0, usr_rd_data);
        check("usr_strb", {usr_wr_strb, usr_rd_strb}, {m_wstb, m_rstb});
        check("usr_addr_be", {usr_addr, usr_wr_be}, {m_addr, m_be});
        check("usr_wr_data", usr_wr_data, m_wd);
        check("status", {ready, fault, err_spur}, {m_state == 1, m_state == 2, m_err});

        ob_ack0   = ack0;
        ob_ack1   = ack1;
        ob_rdvld0 = rdvld0;
        ob_rdvld1 = rdvld1;
        ob_rdata0 = rdata0;
        ob_rdata1 = rdata1;

        if (reset) begin
            m_state = 0;
            m_q.delete();
            m_last  = 1'b1;
            m_err   = 1'b0;
            m_wstb  = 1'b0;
            m_rstb  = 1'b0;
            m_addr  = '0;
            m_wd    = '0;
            m_be    = '0;
        end else begin
            if (usr_rd_dvld && m_q.size() == 0) m_err = 1'b1;
            if (pop_ok) void'(m_q.pop_front());
            if (g0 && !we0) m_q.push_back(1'b0);
            if (g1 && !we1) m_q.push_back(1'b1);
            m_wstb = 1'b0;
            m_rstb = 1'b0;
            if (g0) begin
                m_last = 1'b0; m_wstb = we0; m_rstb = !we0;
                m_addr = addr0; m_wd = wdata0; m_be = be0;
            end else if (g1) begin
                m_last = 1'b1; m_wstb = we1; m_rstb = !we1;
                m_addr = addr1; m_wd = wdata1; m_be = be1;
            end
            if (m_state != 2 && cal_fail)     m_state = 2;
            else if (m_state == 0 && phy_rdy) m_state = 1;
        end
        @(posedge clk0);
        #1;
    endtask

    task automatic idle_inputs();
        phy_rdy = 0; cal_fail = 0; usr_rd_dvld = 0; usr_rd_data = '0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic go_run();
        phy_rdy = 1;
        tick();
        phy_rdy = 0;
        check("go_run_ready", ready, 1'b1);
    endtask

    initial begin
        int cnt;
        bit act0, act1;

        idle_inputs();
        reset = 1;
        @(posedge clk0);
        #1;
        tick();
        tick();
        check("reset_outputs", {usr_wr_strb, usr_rd_strb, usr_addr, ready, fault, err_spur}, '0);
        reset = 0;

        // Held request while waiting for the PHY, then first write goes through.
        req0 = 1; we0 = 1; addr0 = 22'h2A5; wdata0 = 36'h9_1234_5678; be0 = 4'hF;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            cnt += int'(ob_ack0);
        end
        check("init_no_ack", cnt, 0);
        check("init_not_ready", ready, 1'b0);
        phy_rdy = 1;
        tick();
        phy_rdy = 0;
        check("ready_after_phy", ready, 1'b1);
        tick();
        check("first_ack0", ob_ack0, 1'b1);
        check("first_wr_strb", {usr_wr_strb, usr_addr}, {1'b1, 22'h2A5});
        req0 = 0;
        tick();
        check("wr_strb_one_cycle", usr_wr_strb, 1'b0);

        // Round-robin vectors from a fresh reset.
        for (int i = 0; i < 8; i++) tbl[i] = '{1, 1, 1, 1, (i % 2) == 0, (i % 2) == 1};
        tbl[8]  = '{0, 1, 1, 1, 0, 1};
        tbl[9]  = '{1, 1, 1, 1, 1, 0};
        tbl[10] = '{1, 0, 1, 1, 1, 0};
        tbl[11] = '{1, 1, 1, 1, 0, 1};
        tbl[12] = '{0, 0, 1, 1, 0, 0};
        tbl[13] = '{1, 1, 0, 0, 1, 0};
        do_reset();
        go_run();
        for (int i = 0; i < 14; i++) begin
            req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = AW'(32'h100 + i); wdata0 = DW'(i); be0 = 4'h3;
            req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = AW'(32'h200 + i); wdata1 = DW'(i + 64); be1 = 4'hC;
            tick();
            check($sformatf("rr_ack[%0d]", i), {ob_ack0, ob_ack1}, {tbl[i].a0, tbl[i].a1});
            if (tbl[i].a0) check($sformatf("rr_addr[%0d]", i), usr_addr, AW'(32'h100 + i));
            if (tbl[i].a1) check($sformatf("rr_addr[%0d]", i), usr_addr, AW'(32'h200 + i));
        end
        req0 = 0; req1 = 0;

        // Fill the tag FIFO, stall the next read, release it with a same-cycle return.
        do_reset();
        go_run();
        req0 = 1; we0 = 0;
        cnt = 0;
        for (int i = 0; i < TD; i++) begin
            addr0 = AW'(i);
            tick();
            cnt += int'(ob_ack0);
        end
        check("fill_acks", cnt, TD);
        addr0 = 22'h3FF;
        tick();
        check("read_stall", ob_ack0, 1'b0);
        tick();
        check("read_stall_hold", ob_ack0, 1'b0);
        usr_rd_dvld = 1; usr_rd_data = 36'h55;
        tick();
        check("stall_release", {ob_ack0, ob_rdvld0}, 2'b11);
        req0 = 0;
        cnt = 0;
        for (int i = 0; i < TD; i++) begin
            usr_rd_data = DW'(i);
            tick();
            cnt += int'(ob_rdvld0);
        end
        usr_rd_dvld = 0;
        check("drain_count", cnt, TD);

        // Interleaved reads are returned to their owners in order.
        do_reset();
        go_run();
        req0 = 1; we0 = 0; addr0 = 22'hA; tick();
        req0 = 0; req1 = 1; we1 = 0; addr1 = 22'hB; tick();
        req1 = 0; req0 = 1; addr0 = 22'hC; tick();
        req0 = 0;
        usr_rd_dvld = 1;
        usr_rd_data = 36'h1; tick();
        check("ret_a", {ob_rdvld0, ob_rdvld1, ob_rdata0}, {1'b1, 1'b0, 36'h1});
        usr_rd_data = 36'h2; tick();
        check("ret_b", {ob_rdvld0, ob_rdvld1, ob_rdata1}, {1'b0, 1'b1, 36'h2});
        usr_rd_data = 36'h3; tick();
        check("ret_c", {ob_rdvld0, ob_rdvld1, ob_rdata0}, {1'b1, 1'b0, 36'h3});

        // Spurious return, then calibration failure with one read still in flight.
        usr_rd_data = 36'h4; tick();
        usr_rd_dvld = 0;
        check("spur_set", {err_spur, ob_rdvld0, ob_rdvld1}, 3'b100);
        for (int i = 0; i < 3; i++) tick();
        check("spur_sticky", err_spur, 1'b1);
        req1 = 1; we1 = 0; addr1 = 22'h77; tick();
        req1 = 0;
        cal_fail = 1; tick();
        cal_fail = 0;
        check("fault_set", {fault, ready}, 2'b10);
        req0 = 1; we0 = 1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += int'(ob_ack0);
        end
        check("fault_no_ack", cnt, 0);
        usr_rd_dvld = 1; usr_rd_data = 36'h7; tick();
        usr_rd_dvld = 0; req0 = 0;
        check("fault_route", {ob_rdvld1, ob_rdata1}, {1'b1, 36'h7});

        // Reset with five reads outstanding discards the tags.
        do_reset();
        go_run();
        we0 = 0; we1 = 0;
        for (int i = 0; i < 5; i++) begin
            req0 = (i % 2) == 0; req1 = (i % 2) == 1;
            addr0 = AW'(i); addr1 = AW'(i);
            tick();
        end
        req1 = 0; req0 = 1;
        reset = 1; usr_rd_dvld = 1;
        tick();
        check("reset_gates", {ob_ack0, ob_ack1, ob_rdvld0, ob_rdvld1}, 4'b0);
        tick();
        reset = 0; usr_rd_dvld = 0; req0 = 0;
        check("reset_usr_zero", {usr_wr_strb, usr_rd_strb, usr_addr, usr_wr_data, usr_wr_be}, '0);
        check("reset_status", {ready, fault, err_spur}, 3'b000);
        go_run();
        usr_rd_dvld = 1; tick();
        usr_rd_dvld = 0; tick();
        check("spur_after_reset", {err_spur, ob_rdvld0, ob_rdvld1}, 3'b100);

        // Random traffic; requesters hold each command until acked.
        do_reset();
        go_run();
        act0 = 0; act1 = 0;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 599) == 0);
            phy_rdy  = ($urandom_range(0, 3) == 0);
            cal_fail = ($urandom_range(0, 999) == 0);
            if (!act0 && $urandom_range(0, 3) != 0) begin
                act0 = 1; we0 = ($urandom_range(0, 2) == 0);
                addr0 = AW'($urandom()); wdata0 = DW'({$urandom(), $urandom()}); be0 = BW'($urandom());
            end
            if (!act1 && $urandom_range(0, 3) != 0) begin
                act1 = 1; we1 = ($urandom_range(0, 2) == 0);
                addr1 = AW'($urandom()); wdata1 = DW'({$urandom(), $urandom()}); be1 = BW'($urandom());
            end
            req0 = act0; req1 = act1;
            usr_rd_dvld = (m_q.size() > 0) ? ($urandom_range(0, 4) < 2) : ($urandom_range(0, 39) == 0);
            usr_rd_data = DW'({$urandom(), $urandom()});
            tick();
            if (ob_ack0) act0 = 0;
            if (ob_ack1) act1 = 0;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
